// File: rtl/dct_pkg.sv
// ----------------------------------------------------------------------------
// dct_pkg
//   Shared definitions for the DCT systolic array result path.
//   - drain_state_t : result drain FSM states
//   - DCT_* localparams : default array / datapath dimensions
//   - idx_to_rc     : row-major linear index -> (row, col) helper
// No ports (package).
// ----------------------------------------------------------------------------
package dct_pkg;

   localparam int DCT_N         = 8;
   localparam int DCT_ACC_WIDTH = 32;
   localparam int DCT_OUT_WIDTH = 16;
   localparam int DCT_SHIFT     = 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } drain_state_t;

   typedef struct packed {
      logic [15:0] row;
      logic [15:0] col;
   } rc_t;

   // Row-major split of a linear element index for an n x n array.
   function automatic rc_t idx_to_rc(input int unsigned idx, input int unsigned n);
      rc_t rc;
      rc.row = 16'(idx / n);
      rc.col = 16'(idx % n);
      return rc;
   endfunction

endpackage

// File: rtl/drain_scale.sv
// ----------------------------------------------------------------------------
// drain_scale
//   Combinational fixed-point scaler: signed ACC_WIDTH value -> arithmetic
//   right shift by SHIFT -> saturate to signed OUT_WIDTH.
//   Optional feature macro DRAIN_ROUND_EN: adds 2^(SHIFT-1) before the shift
//   (round half toward +inf); otherwise plain floor shift.
//   The work is done in ACC_WIDTH+1 bits so the rounding bias cannot wrap.
// Ports:
//   acc  in  ACC_WIDTH   signed accumulator value
//   q    out OUT_WIDTH   scaled, saturated signed result
// ----------------------------------------------------------------------------
module drain_scale
   import dct_pkg::*;
#(
   parameter int ACC_WIDTH = DCT_ACC_WIDTH,
   parameter int OUT_WIDTH = DCT_OUT_WIDTH,
   parameter int SHIFT     = DCT_SHIFT
)(
   input  logic [ACC_WIDTH-1:0] acc,
   output logic [OUT_WIDTH-1:0] q
);

   localparam int VW = ACC_WIDTH + 1;

   // Saturation bounds expressed in the widened working width.
   localparam logic signed [VW-1:0] MAX_V =
      $signed({{(VW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
   localparam logic signed [VW-1:0] MIN_V =
      $signed({{(VW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

`ifdef DRAIN_ROUND_EN
   localparam logic signed [VW-1:0] ROUND_V =
      $signed({{(VW-1){1'b0}}, 1'b1} << (SHIFT-1));
`endif

   logic signed [VW-1:0] v_s;
   logic signed [VW-1:0] s_s;

   // Sign-extend, optionally bias, shift, then clamp to the output range.
   always_comb begin
`ifdef DRAIN_ROUND_EN
      v_s = $signed({acc[ACC_WIDTH-1], acc}) + ROUND_V;
`else
      v_s = $signed({acc[ACC_WIDTH-1], acc});
`endif
      s_s = v_s >>> SHIFT;
      if (s_s > MAX_V) begin
         q = MAX_V[OUT_WIDTH-1:0];
      end else if (s_s < MIN_V) begin
         q = MIN_V[OUT_WIDTH-1:0];
      end else begin
         q = s_s[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/systolic_result_drain.sv
// ----------------------------------------------------------------------------
// systolic_result_drain
//   Drains the N x N accumulator results of the DCT systolic MAC array.
//   On acc_done (while idle) the whole result vector is snapshotted, pe_clear
//   pulses once so the array can start the next block, and the snapshot is
//   streamed row-major through a valid/ready port, each value scaled and
//   saturated by drain_scale. acc_done while busy is dropped and flagged in
//   the sticky overrun bit.
//   Optional feature macro DRAIN_ROUND_EN (rounding in drain_scale).
// Ports:
//   clk, rst   clock (rising edge), synchronous active-high reset
//   acc_done   in  one-cycle pulse: acc_in holds a finished block
//   acc_in     in  N*N*ACC_WIDTH flattened results, (r,c) at (r*N+c)*ACC_WIDTH
//   pe_clear   out one-cycle pulse to the PE resets, cycle after capture
//   busy       out high while streaming
//   overrun    out sticky: acc_done seen while busy (cleared by rst only)
//   out_valid  out / out_ready in : stream handshake
//   out_data   out scaled, saturated coefficient
//   out_row, out_col, out_last out: position of out_data, last element flag
// ----------------------------------------------------------------------------
module systolic_result_drain
   import dct_pkg::*;
#(
   parameter int N         = DCT_N,
   parameter int ACC_WIDTH = DCT_ACC_WIDTH,
   parameter int OUT_WIDTH = DCT_OUT_WIDTH,
   parameter int SHIFT     = DCT_SHIFT
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            acc_done,
   input  logic [N*N*ACC_WIDTH-1:0]        acc_in,
   output logic                            pe_clear,
   output logic                            busy,
   output logic                            overrun,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [OUT_WIDTH-1:0]            out_data,
   output logic [((N>1)?$clog2(N):1)-1:0]  out_row,
   output logic [((N>1)?$clog2(N):1)-1:0]  out_col,
   output logic                            out_last
);

   localparam int NE = N * N;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

   drain_state_t            state_r;
   logic [IW-1:0]           idx_r;
   logic [NE*ACC_WIDTH-1:0] snapshot_r;
   logic                    pe_clear_r;
   logic                    busy_r;
   logic                    overrun_r;
   logic                    out_valid_r;

   logic [ACC_WIDTH-1:0]    cur_acc_s;
   rc_t                     rc_s;
   logic                    at_last_s;
   logic                    xfer_s;
   logic                    rc_unused_s;

   // Select the current element and derive its position from the index register.
   always_comb begin
      cur_acc_s = snapshot_r[idx_r*ACC_WIDTH +: ACC_WIDTH];
      rc_s      = idx_to_rc(32'(idx_r), N);
      at_last_s = (idx_r == LAST_IDX);
      xfer_s    = out_valid_r & out_ready;
   end

   // Upper position bits are always zero for the configured N.
   assign rc_unused_s = ^{rc_s.row[15:RW], rc_s.col[15:RW]};

   // Drain FSM: capture in IDLE, advance on each accepted transfer in STREAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         idx_r       <= {IW{1'b0}};
         snapshot_r  <= {(NE*ACC_WIDTH){1'b0}};
         pe_clear_r  <= 1'b0;
         busy_r      <= 1'b0;
         overrun_r   <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         pe_clear_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (acc_done) begin
                  snapshot_r  <= acc_in;
                  idx_r       <= {IW{1'b0}};
                  state_r     <= STREAM;
                  pe_clear_r  <= 1'b1;
                  busy_r      <= 1'b1;
                  out_valid_r <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            STREAM: begin
               // A new block while draining cannot be stored; flag it and drop it.
               if (acc_done) begin
                  overrun_r <= 1'b1;
               end else begin
                  overrun_r <= overrun_r;
               end
               if (xfer_s) begin
                  if (at_last_s) begin
                     state_r     <= IDLE;
                     idx_r       <= {IW{1'b0}};
                     busy_r      <= 1'b0;
                     out_valid_r <= 1'b0;
                  end else begin
                     idx_r <= idx_r + IW'(1);
                  end
               end else begin
                  idx_r <= idx_r;
               end
            end
            default: begin
               state_r     <= IDLE;
               idx_r       <= {IW{1'b0}};
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   drain_scale #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_scale (
      .acc (cur_acc_s),
      .q   (out_data)
   );

   assign pe_clear  = pe_clear_r;
   assign busy      = busy_r;
   assign overrun   = overrun_r;
   assign out_valid = out_valid_r;
   assign out_row   = rc_s.row[RW-1:0];
   assign out_col   = rc_s.col[RW-1:0];
   assign out_last  = out_valid_r & at_last_s;

endmodule

// File: tb/tb_systolic_result_drain.sv
// ----------------------------------------------------------------------------
// tb_systolic_result_drain
//   Directed bench for systolic_result_drain with N=2, ACC_WIDTH=32,
//   OUT_WIDTH=16, SHIFT=8. Expected values are hand-computed; the rounding
//   case switches on DRAIN_ROUND_EN to match the build.
// ----------------------------------------------------------------------------
module tb_systolic_result_drain;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int OW = 16;
   localparam int SH = 8;

`ifdef DRAIN_ROUND_EN
   localparam int E_P384 = 2;
   localparam int E_M384 = -1;
`else
   localparam int E_P384 = 1;
   localparam int E_M384 = -2;
`endif

   logic              clk;
   logic              rst;
   logic              acc_done;
   logic [N*N*AW-1:0] acc_in;
   logic              pe_clear;
   logic              busy;
   logic              overrun;
   logic              out_valid;
   logic              out_ready;
   logic [OW-1:0]     out_data;
   logic [0:0]        out_row;
   logic [0:0]        out_col;
   logic              out_last;

   int n_checks = 0;
   int n_fail   = 0;
   int xfers    = 0;
   int x0;

   systolic_result_drain #(
      .N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH)
   ) dut (
      .clk(clk), .rst(rst), .acc_done(acc_done), .acc_in(acc_in),
      .pe_clear(pe_clear), .busy(busy), .overrun(overrun),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count handshakes; sampled mid-cycle, each one completes at the next rising edge.
   always @(negedge clk) begin
      if (out_valid && out_ready) xfers <= xfers + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic elem(input string tag, input int d, input int r, input int c, input int last);
      chk({tag, ".valid"}, int'(out_valid), 1);
      chk({tag, ".data"},  int'($signed(out_data)), d);
      chk({tag, ".row"},   int'(out_row), r);
      chk({tag, ".col"},   int'(out_col), c);
      chk({tag, ".last"},  int'(out_last), last);
   endtask

   function automatic logic [N*N*AW-1:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                                input logic [31:0] a2, input logic [31:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   initial begin
      rst       = 1'b1;
      acc_done  = 1'b0;
      out_ready = 1'b0;
      acc_in    = '0;
      tick();
      tick();

      // Reset state
      chk("rst.busy",      int'(busy), 0);
      chk("rst.valid",     int'(out_valid), 0);
      chk("rst.pe_clear",  int'(pe_clear), 0);
      chk("rst.overrun",   int'(overrun), 0);
      chk("rst.last",      int'(out_last), 0);
      chk("rst.data",      int'($signed(out_data)), 0);
      chk("rst.row",       int'(out_row), 0);
      chk("rst.col",       int'(out_col), 0);
      rst = 1'b0;
      tick();

      // 1: basic stream with saturation on the last element
      acc_in    = pack4(32'd256, 32'd512, 32'hFFFF_FF00, 32'h7FFF_FFFF);
      acc_done  = 1'b1;
      out_ready = 1'b1;
      tick();
      acc_done = 1'b0;
      chk("t1.pe_clear_t1", int'(pe_clear), 1);
      chk("t1.busy",        int'(busy), 1);
      elem("t1.e0", 1, 0, 0, 0);
      tick();
      chk("t1.pe_clear_t2", int'(pe_clear), 0);
      elem("t1.e1", 2, 0, 1, 0);
      tick();
      elem("t1.e2", -1, 1, 0, 0);
      tick();
      elem("t1.e3", 32767, 1, 1, 1);
      tick();
      chk("t1.valid_end", int'(out_valid), 0);
      chk("t1.busy_end",  int'(busy), 0);
      chk("t1.pe_clear_end", int'(pe_clear), 0);

      // 2+3: rounding vs floor, and saturation at both ends
      acc_in   = pack4(32'd384, 32'hFFFF_FE80, 32'h8000_0000, 32'h0080_0000);
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      chk("t2.overrun", int'(overrun), 0);
      elem("t2.p384", E_P384, 0, 0, 0);
      tick();
      elem("t2.m384", E_M384, 0, 1, 0);
      tick();
      elem("t3.min", -32768, 1, 0, 0);
      tick();
      elem("t3.max", 32767, 1, 1, 1);
      tick();
      chk("t3.busy_end", int'(busy), 0);

      // 4: alternating backpressure
      out_ready = 1'b0;
      acc_in    = pack4(32'd2560, 32'd5120, 32'd7680, 32'd10240);
      acc_done  = 1'b1;
      x0        = xfers;
      tick();
      acc_done = 1'b0;
      chk("t4.pe_clear", int'(pe_clear), 1);
      for (int k = 0; k < 4; k++) begin
         elem("t4.pre", (k + 1) * 10, k / 2, k % 2, (k == 3) ? 1 : 0);
         tick();
         elem("t4.stall", (k + 1) * 10, k / 2, k % 2, (k == 3) ? 1 : 0);
         chk("t4.busy", int'(busy), 1);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      chk("t4.valid_end", int'(out_valid), 0);
      chk("t4.busy_end",  int'(busy), 0);
      chk("t4.xfers",     xfers - x0, 4);

      // 5: acc_done while busy is dropped and flagged
      out_ready = 1'b1;
      acc_in    = pack4(32'd256, 32'd512, 32'd768, 32'd1024);
      acc_done  = 1'b1;
      tick();
      acc_done = 1'b0;
      elem("t5.e0", 1, 0, 0, 0);
      chk("t5.overrun0", int'(overrun), 0);
      acc_in   = pack4(32'd25600, 32'd51200, 32'd76800, 32'd102400);
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      chk("t5.overrun1",  int'(overrun), 1);
      chk("t5.pe_clear",  int'(pe_clear), 0);
      elem("t5.e1", 2, 0, 1, 0);
      tick();
      elem("t5.e2", 3, 1, 0, 0);
      tick();
      elem("t5.e3", 4, 1, 1, 1);
      tick();
      chk("t5.busy_end", int'(busy), 0);
      tick();
      chk("t5.sticky", int'(overrun), 1);
      chk("t5.idle_valid", int'(out_valid), 0);

      // 6: reset mid-stream, then a clean block
      acc_in   = pack4(32'd256, 32'd512, 32'd768, 32'd1024);
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      elem("t6.e0", 1, 0, 0, 0);
      tick();
      elem("t6.e1", 2, 0, 1, 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6.valid",    int'(out_valid), 0);
      chk("t6.busy",     int'(busy), 0);
      chk("t6.pe_clear", int'(pe_clear), 0);
      chk("t6.overrun",  int'(overrun), 0);
      chk("t6.row",      int'(out_row), 0);
      chk("t6.col",      int'(out_col), 0);
      tick();
      chk("t6.pe_clear2", int'(pe_clear), 0);
      acc_in   = pack4(32'd25600, 32'd51200, 32'd76800, 32'd102400);
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      chk("t6.new_pe_clear", int'(pe_clear), 1);
      elem("t6.n0", 100, 0, 0, 0);
      tick();
      elem("t6.n1", 200, 0, 1, 0);
      tick();
      elem("t6.n2", 300, 1, 0, 0);
      tick();
      elem("t6.n3", 400, 1, 1, 1);
      tick();
      chk("t6.busy_end", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
